// File: rtl/prog_loader.sv
// prog_loader: loads a length/data/checksum framed byte stream into program memory, holding the CPU in reset until the image verifies
module prog_loader #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int MAX_LEN = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] byte_count
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
  state_t state;
  logic [11:0] len;
  logic [7:0] acc;
  logic xfer;
  logic too_long;
  logic last_data;
  logic [11:0] full_len;
  logic [ADDR_W-1:0] next_count;
  assign xfer = byte_valid & byte_ready;
  assign full_len = {len[11:8], byte_in};
  assign too_long = int'(full_len) > MAX_LEN;
  assign next_count = byte_count + ADDR_W'(1);
  assign last_data = int'(next_count) == int'(len);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      byte_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= BASE_ADDR;
      mem_wdata <= '0;
      cpu_hold <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      byte_count <= '0;
      acc <= '0;
      len <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= LEN_HI;
          byte_ready <= 1'b1;
          cpu_hold <= 1'b1;
          done <= 1'b0;
          error <= 1'b0;
          byte_count <= '0;
          acc <= '0;
          mem_addr <= BASE_ADDR;
        end
        LEN_HI: if (xfer) begin
          if (|byte_in[7:4]) begin
            state <= ERR;
            byte_ready <= 1'b0;
            error <= 1'b1;
          end else begin
            len[11:8] <= byte_in[3:0];
            state <= LEN_LO;
          end
        end
        LEN_LO: if (xfer) begin
          len[7:0] <= byte_in;
          if (full_len == '0) state <= CSUM;
          else if (too_long) begin
            state <= ERR;
            byte_ready <= 1'b0;
            error <= 1'b1;
          end else state <= DATA;
        end
        DATA: if (xfer) begin
          mem_we <= 1'b1;
          mem_wdata <= byte_in;
          mem_addr <= BASE_ADDR + byte_count;
          byte_count <= next_count;
          acc <= acc + byte_in;
          state <= last_data ? CSUM : DATA;
        end
        CSUM: if (xfer) begin
          byte_ready <= 1'b0;
          if (byte_in == acc) begin
            state <= DONE;
            done <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writes a program image into the 4K x 8 program memory, one byte per handshake; the CPU fetch path reads that memory back.
- Bytes arrive on a valid/ready byte stream from the host link, framed as a 12-bit length, the data bytes, then a checksum.
- Holds the CPU in reset for the whole load and releases it only when the checksum matches.

Parameters:
ADDR_W, 12, program memory address width
BASE_ADDR, 12'h000, address the first data byte is written to
MAX_LEN, 4095, largest accepted length; longer frames go to ERR

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR
byte_in  in  8  incoming stream byte
byte_valid  in  1  byte_in is valid
byte_ready  out  1  loader can accept a byte this cycle
mem_we  out  1  program memory write strobe, one cycle per data byte
mem_addr  out  ADDR_W  program memory write address
mem_wdata  out  8  program memory write data
cpu_hold  out  1  drives the CPU reset while loading
done  out  1  sticky; last load passed its checksum
error  out  1  sticky; last load failed
byte_count  out  ADDR_W  data bytes written so far in the current load

Behaviour:
- Reset values: state IDLE; byte_ready, mem_we, done, error and cpu_hold = 0; mem_addr = BASE_ADDR; mem_wdata = 0; byte_count = 0; checksum accumulator = 0; length register = 0.
- Reset is synchronous and overrides everything, including a load in progress. The partially written image is left in memory and done stays 0.
- Transfer rule: a byte is taken only on a rising edge where byte_valid and byte_ready are both 1.
  - byte_ready is 1 exactly in LEN_HI, LEN_LO, DATA and CSUM.
  - byte_ready is driven from the state register, not combinationally from byte_valid.
- All outputs are registered.

States and transitions:
- IDLE. start -> LEN_HI. Same edge: cpu_hold = 1, done = 0, error = 0, byte_count = 0, accumulator = 0, mem_addr = BASE_ADDR.
- LEN_HI. On transfer: bits [7:4] must be 0, else -> ERR. Otherwise store bits [3:0] as length[11:8] and go to LEN_LO.
- LEN_LO. On transfer: store length[7:0].
  - Full length = 0 -> CSUM.
  - Full length > MAX_LEN -> ERR.
  - Otherwise -> DATA.
- DATA. On transfer, registered in the next cycle:
  - mem_we = 1, mem_wdata = byte_in, mem_addr = BASE_ADDR + byte_count (ADDR_W-bit wrap).
  - byte_count increments; accumulator += byte_in (mod 256).
  - When byte_count reaches length on this transfer -> CSUM.
  - mem_we is 0 in every cycle that follows a non-transfer cycle, so a stalled stream produces no writes.
- CSUM. On transfer:
  - byte_in == accumulator -> DONE, with done = 1 and cpu_hold = 0 on that edge.
  - Otherwise -> ERR, with error = 1 and cpu_hold staying 1.
- DONE. start -> LEN_HI, behaving exactly as from IDLE.
- ERR. start -> LEN_HI, behaving exactly as from IDLE. Otherwise stays in ERR with cpu_hold = 1.
- start asserted in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- byte_valid outside the four accepting states is ignored (byte_ready = 0, nothing consumed).
- Write latency: byte accepted on edge k -> mem_we/mem_addr/mem_wdata valid for the cycle between edges k and k+1. The final data write and the CSUM-state entry both happen on edge k.
- Address wrap: with BASE_ADDR + length > 4096 the address wraps modulo 2^ADDR_W. byte_count never wraps because length ≤ MAX_LEN.
- Checksum covers data bytes only. Length bytes are excluded.

Test Plan:
1. reset for 2 cycles -> all outputs at reset values, byte_ready = 0, cpu_hold = 0, mem_addr = 000.
2. Basic load:
   - Stimulus: start; stream 00,03,A1,B2,C3,16 with byte_valid held high.
   - Writes: 3 mem_we pulses, (000,A1), (001,B2), (002,C3).
   - End state: done = 1, cpu_hold = 0, byte_count = 3, error = 0.
3. Stalled stream:
   - Stimulus: same frame as test 2, with byte_valid low for 3 cycles between each byte.
   - Response: identical write sequence and result to test 2; mem_we never high in stall cycles.
4. Bad checksum: frame 00,02,10,20,31 -> writes occur; error = 1, done = 0, cpu_hold = 1. A following start plus a good frame 00,01,55,55 -> done = 1.
5. Header errors:
   - Frame 10,00 -> ERR right after the first byte, no writes.
   - Frame 00,00,00 -> DONE with zero writes.
   - With MAX_LEN = 16, frame 00,11 -> ERR.
6. Interruptions:
   - reset asserted after the 2nd data byte of a 4-byte load -> next cycle is IDLE, done = 0, cpu_hold = 0.
   - start pulsed mid-DATA -> ignored; the load completes normally.
